// File: rtl/display_bcd_sequencer.sv
// display_bcd_sequencer
//   Front end for the 8-digit seven-segment driver. Takes a binary value over
//   a valid/ready handshake, converts it to BCD with a sequential double-dabble
//   engine, applies leading-zero blanking and decimal-point placement, then
//   holds the resulting word stable until the next update.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  handshake; ready only while idle
//   in_value        unsigned binary value to display
//   in_dp_en/pos    light the decimal point of digit in_dp_pos (0 = rightmost)
//   in_blank_lz     enable leading-zero blanking
//   bcd_out         digit i in bits [4i+3:4i]
//   decimal_points  bit i lights the dp of digit i
//   overflow        last accepted value exceeded 99_999_999
//   done            one-cycle pulse when the outputs have just updated
module display_bcd_sequencer #(
  parameter int unsigned BIN_WIDTH  = 27,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] in_value,
  input  logic                 in_dp_en,
  input  logic [2:0]           in_dp_pos,
  input  logic                 in_blank_lz,
  output logic [31:0]          bcd_out,
  output logic [7:0]           decimal_points,
  output logic                 overflow,
  output logic                 done
);

  localparam int unsigned CntW = $clog2(BIN_WIDTH);
  localparam logic [BIN_WIDTH-1:0] MaxVal = BIN_WIDTH'(99_999_999);

  typedef enum logic [1:0] {StIdle, StConvert, StBlank, StUpdate} state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_sr_q, bin_sr_d;
  logic [31:0]          bcd_sr_q, bcd_sr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 dp_en_q, dp_en_d;
  logic [2:0]           dp_pos_q, dp_pos_d;
  logic                 blank_lz_q, blank_lz_d;
  logic [31:0]          disp_q, disp_d;
  logic [7:0]           dpw_q, dpw_d;
  logic [31:0]          bcd_out_q, bcd_out_d;
  logic [7:0]           dp_out_q, dp_out_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 done_q, done_d;

  logic [31:0] bcd_adj;
  logic [2:0]  msd;
  logic [2:0]  keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bin_sr_q   <= '0;
      bcd_sr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dp_en_q    <= 1'b0;
      dp_pos_q   <= '0;
      blank_lz_q <= 1'b0;
      disp_q     <= {8{BLANK_CODE}};
      dpw_q      <= '0;
      bcd_out_q  <= {8{BLANK_CODE}};
      dp_out_q   <= '0;
      ovf_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_sr_q   <= bin_sr_d;
      bcd_sr_q   <= bcd_sr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dp_en_q    <= dp_en_d;
      dp_pos_q   <= dp_pos_d;
      blank_lz_q <= blank_lz_d;
      disp_q     <= disp_d;
      dpw_q      <= dpw_d;
      bcd_out_q  <= bcd_out_d;
      dp_out_q   <= dp_out_d;
      ovf_out_q  <= ovf_out_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_sr_d   = bin_sr_q;
    bcd_sr_d   = bcd_sr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    dp_en_d    = dp_en_q;
    dp_pos_d   = dp_pos_q;
    blank_lz_d = blank_lz_q;
    disp_d     = disp_q;
    dpw_d      = dpw_q;
    bcd_out_d  = bcd_out_q;
    dp_out_d   = dp_out_q;
    ovf_out_d  = ovf_out_q;
    done_d     = 1'b0;
    bcd_adj    = bcd_sr_q;
    msd        = '0;
    keep       = '0;

    // Per-nibble add-3 correction; 4-bit adds, no carry into the next nibble.
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd_sr_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
    end

    // Most-significant nonzero digit of the finished conversion.
    for (int unsigned i = 0; i < 8; i++) begin
      if (bcd_sr_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    keep = (dp_en_q && (dp_pos_q > msd)) ? dp_pos_q : msd;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_sr_d   = in_value;
          bcd_sr_d   = '0;
          cnt_d      = CntW'(BIN_WIDTH - 1);
          ovf_d      = (in_value > MaxVal);
          dp_en_d    = in_dp_en;
          dp_pos_d   = in_dp_pos;
          blank_lz_d = in_blank_lz;
          state_d    = StConvert;
        end
      end
      StConvert: begin
        {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;
        if (cnt_q == '0) state_d = StBlank;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StBlank: begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (blank_lz_q && (3'(i) > keep)) disp_d[4*i +: 4] = BLANK_CODE;
          else                              disp_d[4*i +: 4] = bcd_sr_q[4*i +: 4];
        end
        dpw_d = dp_en_q ? (8'b1 << dp_pos_q) : 8'h00;
        if (ovf_q) begin
          disp_d = {8{BLANK_CODE}};
          dpw_d  = 8'h00;
        end
        state_d = StUpdate;
      end
      StUpdate: begin
        bcd_out_d = disp_q;
        dp_out_d  = dpw_q;
        ovf_out_d = ovf_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready       = (state_q == StIdle);
  assign bcd_out        = bcd_out_q;
  assign decimal_points = dp_out_q;
  assign overflow       = ovf_out_q;
  assign done           = done_q;

endmodule

// File: tb/tb_display_bcd_sequencer.sv
module tb_display_bcd_sequencer;
  localparam int unsigned BW = 27;
  localparam int Latency = 29;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_value;
  logic          in_dp_en;
  logic [2:0]    in_dp_pos;
  logic          in_blank_lz;
  logic [31:0]   bcd_out;
  logic [7:0]    decimal_points;
  logic          overflow;
  logic          done;

  display_bcd_sequencer #(.BIN_WIDTH(BW), .BLANK_CODE(4'hF)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .in_dp_en       (in_dp_en),
    .in_dp_pos      (in_dp_pos),
    .in_blank_lz    (in_blank_lz),
    .bcd_out        (bcd_out),
    .decimal_points (decimal_points),
    .overflow       (overflow),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic        ovf;
    int          t;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] last_bcd = 32'hFFFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, then blanking and dp rules.
  function automatic exp_t model(input logic [31:0] v, input logic de, input logic [2:0] dpp,
                                 input logic blz);
    exp_t e;
    int unsigned x;
    int msd;
    int keep;
    logic [3:0] d [8];
    x = v;
    msd = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = 4'(x % 10);
      x = x / 10;
      if (d[i] != 0) msd = i;
    end
    keep = (de && int'(dpp) > msd) ? int'(dpp) : msd;
    for (int i = 0; i < 8; i++) e.bcd[4*i +: 4] = (blz && i > keep) ? 4'hF : d[i];
    e.dp  = de ? 8'(1 << dpp) : 8'h00;
    e.ovf = (v > 32'd99_999_999);
    if (e.ovf) begin
      e.bcd = 32'hFFFF_FFFF;
      e.dp  = 8'h00;
    end
    e.t = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.bcd));
        check("decimal_points", 64'(decimal_points), 64'(e.dp));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("latency", 64'(cyc - e.t), 64'(Latency));
        last_bcd = e.bcd;
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic de, input logic [2:0] dpp,
                      input logic blz);
    exp_t e;
    int w;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      check("ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid    = 1'b1;
    in_value    = v[BW-1:0];
    in_dp_en    = de;
    in_dp_pos   = dpp;
    in_blank_lz = blz;
    e   = model(v, de, dpp, blz);
    e.t = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_value    = '0;
    in_dp_en    = 1'b0;
    in_dp_pos   = '0;
    in_blank_lz = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_bcd", 64'(bcd_out), 64'hFFFF_FFFF);
    check("rst_dp", 64'(decimal_points), 64'h00);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    send(32'd12_345_678, 1'b0, 3'd0, 1'b1);
    wait_drain();
    send(32'd42, 1'b1, 3'd2, 1'b1);
    wait_drain();
    send(32'd0, 1'b0, 3'd0, 1'b1);
    send(32'd0, 1'b0, 3'd0, 1'b0);
    send(32'd100_000_000, 1'b1, 3'd3, 1'b1);
    send(32'd7, 1'b0, 3'd0, 1'b1);
    send(32'd99_999_999, 1'b1, 3'd7, 1'b1);
    send(32'd134_217_727, 1'b0, 3'd0, 1'b0);
    send(32'd5, 1'b1, 3'd6, 1'b1);
    send(32'd3_000, 1'b1, 3'd1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      send(32'($urandom_range(99_999_999)), 1'($urandom_range(1)), 3'($urandom_range(7)),
           1'($urandom_range(1)));
    end
    wait_drain();

    // Busy input is ignored, outputs hold, then reset aborts the conversion.
    send(32'd55_555_555, 1'b1, 3'd4, 1'b1);
    repeat (4) @(negedge clk);
    in_valid = 1'b1;
    in_value = 27'd1;
    check("busy_ready", 64'(in_ready), 64'd0);
    check("hold_during_convert", 64'(bcd_out), 64'(last_bcd));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    check("abort_bcd", 64'(bcd_out), 64'hFFFF_FFFF);
    check("abort_dp", 64'(decimal_points), 64'h00);
    check("abort_ovf", 64'(overflow), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_hold_bcd", 64'(bcd_out), 64'hFFFF_FFFF);

    send(32'd2_024, 1'b1, 3'd0, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
